// File: rtl/keypad_shot_entry.sv
// Keypad shot entry: debounces the held keypad code into discrete presses and
// runs a row/confirm/column/confirm protocol to present a (row, col) shot.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ARM      | wait for first stable code after reset; absorb it, no press
//  WAIT_ROW | waiting for row digit (F/E ignored)
//  CONF_ROW | row held; F confirms, digit replaces, E clears
//  WAIT_COL | waiting for column digit; E clears, F is an error
//  CONF_COL | column held; F issues, digit replaces, E clears
//  ISSUE    | shot presented; presses swallowed until accepted
module keypad_shot_entry #(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int GRID_MAX      = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  input  logic       shot_ready,
  output logic [2:0] shot_row,
  output logic [2:0] shot_col,
  output logic       shot_valid,
  output logic [2:0] entry_phase,
  output logic       err
);

  localparam int              CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_TC  = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]      DIG_MAX = 4'(GRID_MAX);
  localparam logic [3:0]      KEY_F   = 4'hF;
  localparam logic [3:0]      KEY_E   = 4'hE;

  typedef enum logic [2:0] {
    ARM      = 3'd0,
    WAIT_ROW = 3'd1,
    CONF_ROW = 3'd2,
    WAIT_COL = 3'd3,
    CONF_COL = 3'd4,
    ISSUE    = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    cand, last_acc;
  logic [CW-1:0] cnt;
  logic          stable, press, arm_done;
  logic          is_digit, is_f, is_e;
  logic [2:0]    row_nxt, col_nxt;
  logic          err_nxt;

  // A code counts once it has sat unchanged for STABLE_CYCLES samples.
  assign stable   = (key == cand) && (cnt == CNT_TC);
  assign arm_done = stable && (state == ARM);
  assign press    = stable && (cand != last_acc) && (state != ARM);

  assign is_digit = (cand <= DIG_MAX);
  assign is_f     = (cand == KEY_F);
  assign is_e     = (cand == KEY_E);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand     <= '0;
      cnt      <= '0;
      last_acc <= '0;
    end else begin
      if (key != cand) begin
        cand <= key;
        cnt  <= '0;
      end else if (cnt != CNT_TC) begin
        cnt <= cnt + 1'b1;
      end
      if (arm_done || press)
        last_acc <= cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARM;
      shot_row <= '0;
      shot_col <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      shot_row <= row_nxt;
      shot_col <= col_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = shot_row;
    col_nxt   = shot_col;
    err_nxt   = 1'b0;
    case (state)
      ARM: begin
        if (arm_done)
          state_nxt = WAIT_ROW;
      end
      WAIT_ROW: begin
        if (press) begin
          if (is_digit) begin
            row_nxt   = cand[2:0];
            state_nxt = CONF_ROW;
          end else if (!is_f && !is_e) begin
            err_nxt = 1'b1;
          end
        end
      end
      CONF_ROW: begin
        if (press) begin
          if (is_digit) begin
            row_nxt = cand[2:0];
          end else if (is_f) begin
            state_nxt = WAIT_COL;
          end else if (is_e) begin
            row_nxt   = '0;
            col_nxt   = '0;
            state_nxt = WAIT_ROW;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      WAIT_COL: begin
        if (press) begin
          if (is_digit) begin
            col_nxt   = cand[2:0];
            state_nxt = CONF_COL;
          end else if (is_e) begin
            row_nxt   = '0;
            col_nxt   = '0;
            state_nxt = WAIT_ROW;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      CONF_COL: begin
        if (press) begin
          if (is_digit) begin
            col_nxt = cand[2:0];
          end else if (is_f) begin
            state_nxt = ISSUE;
          end else if (is_e) begin
            row_nxt   = '0;
            col_nxt   = '0;
            state_nxt = WAIT_ROW;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ISSUE: begin
        // Row/col stay frozen; any press here is absorbed via last_acc only.
        if (shot_ready)
          state_nxt = WAIT_ROW;
      end
      default: state_nxt = ARM;
    endcase
  end

  assign shot_valid  = (state == ISSUE);
  assign entry_phase = state;

endmodule

// File: tb/tb_keypad_shot_entry.sv
// Directed bench for keypad_shot_entry with STABLE_CYCLES=4, GRID_MAX=7.
// Inputs change and outputs are sampled on the falling edge.
module tb_keypad_shot_entry;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic       shot_ready;
  logic [2:0] shot_row, shot_col, entry_phase;
  logic       shot_valid, err;

  int n_vec  = 0;
  int n_miss = 0;
  int err_seen = 0;

  keypad_shot_entry #(.STABLE_CYCLES(4), .GRID_MAX(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .shot_ready  (shot_ready),
    .shot_row    (shot_row),
    .shot_col    (shot_col),
    .shot_valid  (shot_valid),
    .entry_phase (entry_phase),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Counts err cycles; reads the pre-edge value so each pulse counts once.
  always @(posedge clk)
    if (rst_n && err) err_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input logic [3:0] k, input int n);
    key = k;
    step(n);
  endtask

  initial begin
    rst_n      = 1'b0;
    key        = 4'h0;
    shot_ready = 1'b0;
    #3;
    chk("rst_phase", entry_phase, 0);
    chk("rst_valid", shot_valid, 0);
    chk("rst_row",   shot_row, 0);
    chk("rst_err",   err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic entry 3,F,5,F with ready already high
    apply(4'h0, 6);
    chk("arm_exit", entry_phase, 1);
    apply(4'h3, 4);
    chk("lat_early_phase", entry_phase, 1);
    step(2);
    chk("row3_phase", entry_phase, 2);
    chk("row3", shot_row, 3);
    apply(4'hF, 6);
    chk("confrow_phase", entry_phase, 3);
    apply(4'h5, 6);
    chk("col5_phase", entry_phase, 4);
    chk("col5", shot_col, 5);
    shot_ready = 1'b1;
    apply(4'hF, 4);
    chk("pre_issue_valid", shot_valid, 0);
    step(1);
    chk("shot1_valid", shot_valid, 1);
    chk("shot1_row", shot_row, 3);
    chk("shot1_col", shot_col, 5);
    chk("shot1_phase", entry_phase, 5);
    step(1);
    chk("shot1_drop", shot_valid, 0);
    chk("shot1_back", entry_phase, 1);
    chk("shot1_row_kept", shot_row, 3);

    // same digit for row and column; long hold is one press
    apply(4'h3, 20);
    chk("rep_phase", entry_phase, 2);
    apply(4'hF, 6);
    apply(4'h3, 6);
    chk("rep_col_phase", entry_phase, 4);
    chk("rep_col", shot_col, 3);
    apply(4'hF, 5);
    chk("shot2_valid", shot_valid, 1);
    chk("shot2_rc", {shot_row, shot_col}, {3'd3, 3'd3});
    step(1);
    chk("shot2_drop", shot_valid, 0);

    // illegal key then short glitch
    apply(4'h9, 5);
    chk("ill_err", err, 1);
    chk("ill_phase", entry_phase, 1);
    step(1);
    chk("ill_err_clr", err, 0);
    apply(4'h2, 3);
    apply(4'h9, 6);
    chk("glitch_phase", entry_phase, 1);
    chk("glitch_row", shot_row, 3);
    chk("err_count1", err_seen, 1);

    // correction and clear
    apply(4'h2, 6);
    chk("corr_row2", shot_row, 2);
    apply(4'h6, 6);
    chk("corr_row6", shot_row, 6);
    chk("corr_phase", entry_phase, 2);
    apply(4'hF, 6);
    apply(4'h1, 6);
    chk("clr_pre_col", shot_col, 1);
    apply(4'hE, 6);
    chk("clr_rc", {shot_row, shot_col}, 0);
    chk("clr_phase", entry_phase, 1);

    // backpressure with presses during ISSUE
    shot_ready = 1'b0;
    apply(4'h4, 6);
    apply(4'hF, 6);
    apply(4'h7, 6);
    apply(4'hF, 6);
    chk("bp_valid0", shot_valid, 1);
    apply(4'h4, 20);
    apply(4'hF, 30);
    chk("bp_valid", shot_valid, 1);
    chk("bp_rc", {shot_row, shot_col}, {3'd4, 3'd7});
    chk("bp_phase", entry_phase, 5);
    chk("bp_no_err", err_seen, 1);
    shot_ready = 1'b1;
    step(1);
    chk("bp_drop", shot_valid, 0);
    chk("bp_back", entry_phase, 1);

    // async reset during CONF_COL
    shot_ready = 1'b0;
    apply(4'h1, 6);
    apply(4'hF, 6);
    apply(4'h2, 6);
    chk("cc_phase", entry_phase, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("ar1_phase", entry_phase, 0);
    chk("ar1_rc", {shot_row, shot_col}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'h2, 6);
    chk("ar1_rearm", entry_phase, 1);
    chk("ar1_nopress", shot_row, 0);

    // async reset during ISSUE, then power-up value held
    apply(4'h5, 6);
    apply(4'hF, 6);
    apply(4'h6, 6);
    apply(4'hF, 6);
    chk("ar2_pre_valid", shot_valid, 1);
    #2 rst_n = 1'b0;
    key = 4'h0;
    #1;
    chk("ar2_valid", shot_valid, 0);
    chk("ar2_phase", entry_phase, 0);
    chk("ar2_rc", {shot_row, shot_col}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    chk("ar2_arm_hold", entry_phase, 0);
    step(1);
    chk("ar2_arm_exit", entry_phase, 1);
    step(16);
    chk("ar2_nopress", entry_phase, 1);
    chk("ar2_row", shot_row, 0);
    chk("err_count_end", err_seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
